frame_uart_tx: RTL
==================

Name: frame_uart_tx

Overview:
Streams a processed frame out of the output frame buffer over a UART line, 8N1, LSB first. This is the transmit counterpart of the existing receive path that fills the input RAM. On a start pulse it reads FRAME_LEN bytes sequentially from a synchronous-read RAM port, serialises each byte, then pulses done. It sits on the pixel clock domain beside the second frame RAM and drives the board TX pin.

Parameters:
- CLK_HZ, 50000000: input clock frequency in Hz.
- BAUD, 115200: line rate. Bit period DIV = CLK_HZ/BAUD, integer division truncated; DIV >= 2 is required.
- FRAME_LEN, 31250: bytes per frame. Addresses run 0..FRAME_LEN-1.
- ADDR_W, 15: RAM address width. FRAME_LEN <= 2^ADDR_W.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle request to send one frame.
- ram_addr, output, ADDR_W: read address to the frame RAM port B.
- ram_rd_en, output, 1: read strobe, high for exactly one cycle per byte.
- ram_dout, input, 8: RAM read data, valid 1 cycle after ram_rd_en.
- tx, output, 1: serial line; idle high.
- busy, output, 1: high from start acceptance until done.
- done, output, 1: one-cycle pulse after the last stop bit.
- byte_cnt, output, ADDR_W: number of bytes fully sent in the current or last frame.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-byte):
  - tx=1, busy=0, done=0, ram_rd_en=0, ram_addr=0, byte_cnt=0, state IDLE, baud counter 0.
  - There is no partial-byte completion.
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP (plus PARITY when the optional feature is enabled).
- IDLE:
  - A start sampled high at edge E0 sets busy=1, ram_addr=0, ram_rd_en=1, byte_cnt=0 and moves to FETCH.
  - start is ignored in every other state.
- FETCH: ram_rd_en drops to 0 at E1 and the state moves to LOAD.
- LOAD: at E2, ram_dout is captured into the shift register, tx=0 and the baud counter is cleared; the state moves to START.
- START: tx stays 0 for DIV cycles, then moves to DATA with tx=bit0.
- DATA:
  - Each bit is held DIV cycles, LSB first, using a 3-bit bit index.
  - After bit7's DIV cycles, tx=1 and the state moves to STOP.
- STOP: tx stays 1 for DIV cycles, then byte_cnt increments. From there:
  - If ram_addr == FRAME_LEN-1: done=1 for one cycle, busy=0 on the same edge, state IDLE, ram_addr held.
  - Otherwise: ram_addr+1, ram_rd_en=1, state FETCH.
- Byte timing:
  - Per-byte period is exactly 10*DIV + 2 cycles.
  - Between bytes the line idles high for 2 cycles (FETCH, LOAD).
- Baud counter:
  - Width is clog2(DIV).
  - It counts 0..DIV-1; the bit ends when the count equals DIV-1, then the counter wraps to 0.
- Timing references:
  - First tx falling edge is at E2.
  - done is asserted 2 + FRAME_LEN*(10*DIV+2) - 2 cycles after E0, i.e. at the last STOP end.
- A start coincident with the done cycle is ignored, because the state is still STOP at that edge.
- A start arriving in IDLE in the cycle after done is accepted.
- ram_addr never exceeds FRAME_LEN-1; there is no wrap within a frame.

Optional Feature:
- Macro: TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is sent in a PARITY state between bit7 and STOP, for DIV cycles.
  - Frame format becomes 8E1; per-byte period is 11*DIV + 2 cycles.
- Undefined: 8N1 as above, and the PARITY state and logic are absent.

Decomposition:
- Package frame_uart_pkg:
  - state enumeration/localparams (IDLE, FETCH, LOAD, START, DATA, PARITY, STOP).
  - DATA_BITS=8.
  - default CLK_HZ, BAUD and FRAME_LEN constants, shared with the receive path.
- Sub-module uart_baud_gen:
  - parameter DIV; inputs clk, reset_n, clear; output tick (high on the count==DIV-1 cycle).
  - The top FSM advances on tick.

Test Plan:
1. Basic frame:
   - Setup: CLK_HZ=1152000, BAUD=115200 (DIV=10), FRAME_LEN=4, RAM preloaded A5,00,FF,3C.
   - Stimulus: pulse start.
   - Required: tx decodes A5,00,FF,3C in order; each start bit is 10 cycles; byte spacing is 102 cycles; done pulses once; byte_cnt=4; busy low after done.
2. Read interface:
   - Required: ram_rd_en is high exactly 4 times; ram_addr is 0,1,2,3 on those cycles; first tx low occurs 2 cycles after start.
3. Start while busy:
   - Stimulus: a second start pulse mid-byte 1, then a start on the done cycle.
   - Required: both are ignored, only 4 bytes are sent. A start one cycle after done begins a new frame at address 0.
4. Reset mid-byte:
   - Stimulus: assert reset_n=0 during bit3 of byte 2, asynchronous to clk.
   - Required: tx=1, busy=0, ram_addr=0 immediately; no done. After release, start resends the full frame from A5.
5. Parity (TX_PARITY_EN defined):
   - Required: byte A5 carries parity 0, byte 01 carries parity 1; per-byte period is 112 cycles.
6. Long frame:
   - Setup: FRAME_LEN=31250 with BAUD scaled so DIV=2.
   - Required: byte_cnt ends at 31250, last ram_addr is 31249, no address overflow.

Source files
------------

// File: rtl/frame_uart_tx_pkg.sv
// Shared definitions for the frame UART transmit and receive paths.
// Holds the FSM state encoding, the data width and the default
// clock/baud/frame constants used by both directions.
package frame_uart_pkg;

    localparam int unsigned DATA_BITS         = 8;
    localparam int unsigned DEFAULT_CLK_HZ    = 50_000_000;
    localparam int unsigned DEFAULT_BAUD      = 115_200;
    localparam int unsigned DEFAULT_FRAME_LEN = 31_250;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } tx_state_t;

    // Clock cycles per bit, truncated.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/frame_uart_tx_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 and raises tick on the last count.
// A synchronous clear restarts the period so a bit starts exactly on
// the edge that the FSM begins driving it.
module uart_baud_gen #(
    parameter int unsigned DIV = 434
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Free-running period counter with synchronous restart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/frame_uart_tx.sv
// Frame UART transmitter: on start, reads FRAME_LEN bytes from a
// synchronous-read RAM and sends each as 8N1, LSB first, then pulses done.
// Optional macro TX_PARITY_EN adds an even-parity bit (8E1).
// All outputs are registered; every register has a next-value term
// computed in the combinational FSM process.
module frame_uart_tx
    import frame_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD      = DEFAULT_BAUD,
    parameter int unsigned FRAME_LEN = DEFAULT_FRAME_LEN,
    parameter int unsigned ADDR_W    = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [7:0]        ram_dout,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] byte_cnt
);

    localparam int unsigned       DIV       = baud_div(CLK_HZ, BAUD);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t         state, state_n;
    logic              tx_q, tx_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              rd_q, rd_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [ADDR_W-1:0] cnt_q, cnt_n;
    logic [7:0]        shift_q, shift_n;
    logic [2:0]        bit_q, bit_n;
    logic              baud_clear;
    logic              tick;

    // The bit timer restarts on the edge that drives the start bit low.
    assign baud_clear = (state == S_LOAD);

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (baud_clear),
        .tick    (tick)
    );

    // State and output registers; reset abandons any byte in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            bit_q   <= '0;
        end else begin
            state   <= state_n;
            tx_q    <= tx_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            rd_q    <= rd_n;
            addr_q  <= addr_n;
            cnt_q   <= cnt_n;
            shift_q <= shift_n;
            bit_q   <= bit_n;
        end
    end

    // Next-state and next-output logic; strobes default low each cycle.
    always_comb begin
        state_n = state;
        tx_n    = tx_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        rd_n    = 1'b0;
        addr_n  = addr_q;
        cnt_n   = cnt_q;
        shift_n = shift_q;
        bit_n   = bit_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    busy_n  = 1'b1;
                    addr_n  = '0;
                    rd_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                state_n = S_LOAD;
            end
            S_LOAD: begin
                shift_n = ram_dout;
                tx_n    = 1'b0;
                state_n = S_START;
            end
            S_START: begin
                if (tick) begin
                    tx_n    = shift_q[0];
                    bit_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
`ifdef TX_PARITY_EN
                        tx_n    = ^shift_q;
                        state_n = S_PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n = bit_q + 3'd1;
                        tx_n  = shift_q[bit_q + 3'd1];
                    end
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    tx_n    = 1'b1;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    cnt_n = cnt_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = S_IDLE;
                    end else begin
                        addr_n  = addr_q + 1'b1;
                        rd_n    = 1'b1;
                        state_n = S_FETCH;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign ram_addr  = addr_q;
    assign ram_rd_en = rd_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign byte_cnt  = cnt_q;

endmodule
